// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: pipeline MEM stage; passes ALU results through and runs loads/stores as sized bus transactions
//   in_*  : EX handshake (in_valid/in_ready) with access descriptor mem_*, addr, wdata
//   out_* : WB handshake (out_valid/out_ready) with data, fault, fault_cause
//   bus_* : single-outstanding request/ack bus with byte strobes, error response and timeout
//   rst   : asynchronous, active-low
module mem_stage_lsu #(
  parameter int XLEN = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_valid,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   data,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ack,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);
  localparam int SW = XLEN / 8;
  localparam int LW = $clog2(SW);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, BUS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [LW-1:0] off, off_r;
  logic [1:0] size_r;
  logic uns_r;
  logic [2:0] amask;
  logic illegal, tmo;
  logic [SW-1:0] strb;
  logic [6:0] n;
  logic [XLEN-1:0] sh, lsh, sx, ld;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign off = addr[LW-1:0];
  assign amask = 3'((4'd1 << mem_size) - 4'd1);
  assign illegal = |(addr[2:0] & amask) || (XLEN == 32 && mem_size == 2'd3);
  assign strb = ~({SW{1'b1}} << (4'd1 << mem_size)) << off;
  assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  // Extend a load by pushing the access to the top of the word and shifting it back down.
  assign sh = bus_rdata >> {off_r, 3'b000};
  assign n = 7'(XLEN) - (7'd8 << size_r);
  assign lsh = sh << n;
  assign sx = $signed(lsh) >>> n;
  assign ld = uns_r ? lsh >> n : sx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      off_r <= '0;
      size_r <= '0;
      uns_r <= 1'b0;
      out_valid <= 1'b0;
      data <= '0;
      fault <= 1'b0;
      fault_cause <= 2'd0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else if (state == IDLE) begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        data <= '0;
        fault <= 1'b0;
        fault_cause <= 2'd0;
      end
      if (in_valid && in_ready) begin
        if (!mem_valid) begin
          out_valid <= 1'b1;
          data <= addr;
          fault <= 1'b0;
          fault_cause <= 2'd0;
        end else if (illegal) begin
          out_valid <= 1'b1;
          data <= '0;
          fault <= 1'b1;
          fault_cause <= 2'd1;
        end else begin
          state <= BUS;
          cnt <= '0;
          off_r <= off;
          size_r <= mem_size;
          uns_r <= mem_unsigned;
          bus_req <= 1'b1;
          bus_we <= mem_rw;
          bus_addr <= {addr[XLEN-1:LW], {LW{1'b0}}};
          bus_wstrb <= strb;
          bus_wdata <= wdata << {off, 3'b000};
        end
      end
    end else if (bus_err || bus_ack || tmo) begin
      state <= IDLE;
      bus_req <= 1'b0;
      out_valid <= 1'b1;
      fault <= bus_err || !bus_ack;
      fault_cause <= bus_err ? 2'd2 : bus_ack ? 2'd0 : 2'd3;
      data <= (bus_ack && !bus_err && !bus_we) ? ld : '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline MEM stage.
- Sits between EX and WB. Non-memory instructions pass their ALU result through with one cycle of latency.
- Loads and stores run as a real bus transaction: sized accesses (B/H/W/D), byte strobes, sign/zero extension, a wait-state handshake, alignment checks and a bus timeout.
- Valid/ready backpressure on both sides lets the core stall on slow memory.

Parameters:
XLEN, 64, datapath/address width; legal values 32 or 64; STRB_W = XLEN/8 is derived from it.
TIMEOUT, 255, max bus wait cycles before a fault; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage accepts this cycle
mem_valid  in  1  instruction is a memory access
mem_rw  in  1  1=store, 0=load
mem_size  in  2  0=B, 1=H, 2=W, 3=D
mem_unsigned  in  1  load zero-extends when 1
addr  in  XLEN  effective address, or ALU result when mem_valid=0
wdata  in  XLEN  store data, right-aligned
out_valid  out  1  result available to WB
out_ready  in  1  WB consumes the result
data  out  XLEN  load result / pass-through value / 0 for stores and faults
fault  out  1  access faulted
fault_cause  out  2  0=none, 1=misaligned/illegal size, 2=bus error, 3=timeout
bus_req  out  1  bus request
bus_we  out  1  write enable
bus_addr  out  XLEN  address with low log2(STRB_W) bits forced to 0
bus_wstrb  out  STRB_W  byte-lane enables
bus_wdata  out  XLEN  lane-shifted store data
bus_ack  in  1  transfer complete
bus_rdata  in  XLEN  read data, sampled when bus_ack=1
bus_err  in  1  bus error response

Behaviour:
- Reset (asynchronous, rst=0):
  - State IDLE, wait counter 0.
  - All outputs 0: out_valid, data, fault, fault_cause, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata.
  - Reset during BUS aborts the transaction immediately; bus_req falls without waiting for a clock.
- States: IDLE and BUS.
- Ready: in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept: a cycle T with in_valid && in_ready. The output register clears when out_ready && out_valid and no new result loads that cycle.
- Non-memory instruction (mem_valid=0): at T+1, out_valid=1, data=addr, fault=0.
- Illegal access: addr not aligned to 2^mem_size bytes, or mem_size=3 with XLEN=32.
  - No bus activity.
  - At T+1: out_valid=1, fault=1, fault_cause=1, data=0.
- Legal access, registered at T+1:
  - Enter BUS with bus_req=1, bus_we=mem_rw, bus_addr = addr with low lane bits cleared.
  - bus_wstrb = ((1<<2^size)-1) << off, where off = addr mod STRB_W.
  - bus_wdata = wdata << (8*off); bits outside the strobe are don't-care.
  - All bus outputs are held stable while bus_req=1.
- Completion in BUS:
  - First cycle (from T+1) with bus_ack=1 or bus_err=1 ends the request; bus_req=0 on the next edge.
  - Result is registered on that same edge, with out_valid=1, and the state returns to IDLE.
  - bus_err has priority over bus_ack: fault=1, fault_cause=2, data=0.
  - Load ack: data = (bus_rdata >> 8*off), truncated to the access size, then sign-extended (mem_unsigned=0) or zero-extended.
  - Store ack: data=0, fault=0.
- Timeout:
  - Counter is cleared on entering BUS and increments each BUS cycle without ack/err.
  - If TIMEOUT≠0 and a cycle with counter==TIMEOUT-1 has no ack/err, the request ends after that cycle. bus_req is therefore high exactly TIMEOUT cycles.
  - Result: fault=1, fault_cause=3, data=0.
  - bus_ack arriving later while IDLE is ignored.
- Latency:
  - Pass-through and fault: 1 cycle.
  - Bus access with ack in cycle T+1+k: out_valid at T+2+k.
- Outputs hold while out_valid && !out_ready. The bus is never re-requested for the same instruction.

Test Plan:
1. Pass-through: mem_valid=0, addr=0x1234, out_ready=1 -> at T+1 out_valid=1, data=0x1234; back-to-back accepts every cycle.
2. Signed byte load: addr=0x1003, size=0, ack at T+1, bus_rdata=0x00000000_80000000 -> bus_addr=0x1000, wstrb=0x08, data=0xFFFFFFFF_FFFFFF80; with mem_unsigned=1, data=0x80.
3. Halfword store: addr=0x2006, wdata=0xABCD, ack at T+3 -> bus_we=1, wstrb=0xC0, bus_wdata[63:48]=0xABCD, req stable for 3 cycles, out_valid at T+4, data=0.
4. Misaligned word: addr=0x1002, size=2 -> bus_req never asserts; T+1 fault=1, fault_cause=1. XLEN=32 with size=3 -> same result.
5. Errors, TIMEOUT=4: no ack -> bus_req high exactly 4 cycles, then fault_cause=3. Separate access with bus_err=1 and bus_ack=1 together -> fault_cause=2.
6. Backpressure and reset:
   - out_ready=0 for 3 cycles -> in_ready=0, out_valid and data hold.
   - rst=0 mid-BUS -> bus_req drops without a clock edge; all outputs 0; after release, in_ready=1.
